// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI AR/R channel between inst and data sram-like read ports.
// Define AXI_RD_ARB_RR_EN for round-robin grants; default is fixed data-over-inst priority.
module axi_rd_arbiter #(
    parameter int MAX_OUTS = 2
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    input  logic [1:0]  inst_size,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic [31:0] data_addr,
    input  logic [1:0]  data_size,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    input  logic        wr_pend,
    input  logic [31:0] wr_pend_addr,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready
);
    typedef enum logic {IDLE, AR_BUSY} state_t;
    state_t      state_q;
    logic [2:0]  cnt_inst_q, cnt_inst_d, cnt_data_q, cnt_data_d;
    logic        arvalid_q, rready_q;
    logic [3:0]  arid_q;
    logic [31:0] araddr_q;
    logic [2:0]  arsize_q;
    logic        inst_elig, data_elig, raw_hit, can_grant, gnt_inst, gnt_data;
    logic        ar_hs, r_hs;

    function automatic logic [2:0] cnt_next(input logic [2:0] c, input logic inc, input logic dec);
        return (inc && !dec) ? c + 3'd1 : (dec && !inc && c != 3'd0) ? c - 3'd1 : c;
    endfunction

    // Same 32-bit word as the pending write; byte-lane bits are masked off.
    assign raw_hit   = wr_pend && ((data_addr | 32'd3) == (wr_pend_addr | 32'd3));
    assign inst_elig = inst_req && cnt_inst_q < 3'(MAX_OUTS);
    assign data_elig = data_req && cnt_data_q < 3'(MAX_OUTS) && !raw_hit;
    assign can_grant = aresetn && state_q == IDLE;
`ifdef AXI_RD_ARB_RR_EN
    logic last_grant_q;
    assign gnt_data = can_grant && data_elig && (!inst_elig || !last_grant_q);
    always_ff @(posedge aclk) begin
        if (!aresetn) last_grant_q <= 1'b0;
        else if (gnt_inst || gnt_data) last_grant_q <= gnt_data;
    end
`else
    assign gnt_data = can_grant && data_elig;
`endif
    assign gnt_inst     = can_grant && inst_elig && !gnt_data;
    assign inst_addr_ok = gnt_inst;
    assign data_addr_ok = gnt_data;

    assign ar_hs        = arvalid_q && arready;
    assign r_hs         = rvalid && rready_q;
    assign inst_data_ok = r_hs && rid == 4'd0;
    assign data_data_ok = r_hs && rid == 4'd1;
    assign inst_rdata   = rdata;
    assign data_rdata   = rdata;
    assign cnt_inst_d   = cnt_next(cnt_inst_q, ar_hs && arid_q == 4'd0, inst_data_ok);
    assign cnt_data_d   = cnt_next(cnt_data_q, ar_hs && arid_q == 4'd1, data_data_ok);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            arvalid_q  <= 1'b0;
            arid_q     <= 4'd0;
            araddr_q   <= 32'd0;
            arsize_q   <= 3'd0;
            rready_q   <= 1'b0;
            cnt_inst_q <= 3'd0;
            cnt_data_q <= 3'd0;
        end else begin
            rready_q   <= 1'b1;
            cnt_inst_q <= cnt_inst_d;
            cnt_data_q <= cnt_data_d;
            if (gnt_inst || gnt_data) begin
                state_q   <= AR_BUSY;
                arvalid_q <= 1'b1;
                arid_q    <= {3'b000, gnt_data};
                araddr_q  <= gnt_data ? data_addr : inst_addr;
                arsize_q  <= {1'b0, gnt_data ? data_size : inst_size};
            end else if (ar_hs) begin
                state_q   <= IDLE;
                arvalid_q <= 1'b0;
            end
        end
    end

    assign arvalid = arvalid_q;
    assign arid    = arid_q;
    assign araddr  = araddr_q;
    assign arsize  = arsize_q;
    assign rready  = rready_q;
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: directed and random stimulus against a queue-based reference model.
// Define AXI_RD_ARB_RR_EN here too when building the round-robin variant.
module tb_axi_rd_arbiter;
    localparam int MAXO = 2;
    logic        aclk = 1'b0;
    logic        aresetn, inst_req, data_req, wr_pend, arready, rvalid;
    logic [31:0] inst_addr, data_addr, wr_pend_addr, rdata;
    logic [1:0]  inst_size, data_size;
    logic [3:0]  rid;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, arvalid, rready;
    logic [31:0] inst_rdata, data_rdata, araddr;
    logic [3:0]  arid;
    logic [2:0]  arsize;

    axi_rd_arbiter #(.MAX_OUTS(MAXO)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_size(inst_size),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_addr(data_addr), .data_size(data_size),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .wr_pend(wr_pend), .wr_pend_addr(wr_pend_addr),
        .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready)
    );

    always #5 aclk = ~aclk;

    typedef struct {logic [3:0] id; logic [31:0] addr; logic [2:0] size;} ar_t;
    ar_t  exp_ar[$];
    int   dut_grants[$];
    int   osd[2];
    logic rdy_m = 1'b0, last_m = 1'b0;
    int   n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one evaluation per cycle, away from the active edge.
    always @(negedge aclk) begin
        logic m_ie, m_de, m_gi, m_gd, m_idle, m_rb, m_arhs;
        logic [3:0] m_arid;
        ar_t it;
        m_ie   = inst_req && osd[0] < MAXO;
        m_de   = data_req && osd[1] < MAXO && !(wr_pend && data_addr[31:2] == wr_pend_addr[31:2]);
        m_idle = aresetn && exp_ar.size() == 0;
`ifdef AXI_RD_ARB_RR_EN
        m_gd = m_idle && m_de && (!m_ie || !last_m);
`else
        m_gd = m_idle && m_de;
`endif
        m_gi = m_idle && m_ie && !m_gd;
        chk("inst_addr_ok", 32'(inst_addr_ok), 32'(m_gi));
        chk("data_addr_ok", 32'(data_addr_ok), 32'(m_gd));
        chk("rready", 32'(rready), 32'(rdy_m));
        chk("arvalid", 32'(arvalid), 32'(exp_ar.size() != 0));
        if (arvalid && exp_ar.size() != 0) begin
            chk("arid", 32'(arid), 32'(exp_ar[0].id));
            chk("araddr", araddr, exp_ar[0].addr);
            chk("arsize", 32'(arsize), 32'(exp_ar[0].size));
        end
        m_rb = rvalid && rdy_m;
        chk("inst_data_ok", 32'(inst_data_ok), 32'(m_rb && rid == 4'd0));
        chk("data_data_ok", 32'(data_data_ok), 32'(m_rb && rid == 4'd1));
        if (rvalid) begin
            chk("inst_rdata", inst_rdata, rdata);
            chk("data_rdata", data_rdata, rdata);
        end
        if (inst_addr_ok) dut_grants.push_back(0);
        if (data_addr_ok) dut_grants.push_back(1);
        m_arhs = exp_ar.size() != 0 && arready;
        m_arid = 4'hF;
        if (!aresetn) begin
            exp_ar.delete();
            osd = '{0, 0};
            rdy_m = 1'b0;
            last_m = 1'b0;
        end else begin
            if (m_arhs) begin
                it = exp_ar.pop_front();
                m_arid = it.id;
            end
            for (int k = 0; k < 2; k++) begin
                if (m_arhs && m_arid == 4'(k) && !(m_rb && rid == 4'(k))) osd[k]++;
                else if (m_rb && rid == 4'(k) && !(m_arhs && m_arid == 4'(k)) && osd[k] > 0) osd[k]--;
            end
            if (m_gi) begin
                exp_ar.push_back('{4'd0, inst_addr, {1'b0, inst_size}});
                last_m = 1'b0;
            end
            if (m_gd) begin
                exp_ar.push_back('{4'd1, data_addr, {1'b0, data_size}});
                last_m = 1'b1;
            end
            rdy_m = 1'b1;
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle_inputs();
        inst_req = 0; data_req = 0; wr_pend = 0; arready = 0; rvalid = 0;
        inst_addr = 0; data_addr = 0; wr_pend_addr = 0; rdata = 0; rid = 0;
        inst_size = 2'd2; data_size = 2'd2;
    endtask

    task automatic do_reset();
        aresetn = 0;
        idle_inputs();
        repeat (2) tick();
        aresetn = 1;
        dut_grants.delete();
    endtask

    function automatic int count_id(input int id);
        int c = 0;
        foreach (dut_grants[i]) if (dut_grants[i] == id) c++;
        return c;
    endfunction

    initial begin
        int exp_seq[4];
        aresetn = 0;
        idle_inputs();
        inst_req = 1; inst_addr = 32'h1C00_0000;
        repeat (5) tick();
        aresetn = 1; arready = 1;
        dut_grants.delete();
        tick();
        inst_req = 0;
        repeat (2) tick();
        rvalid = 1; rid = 0; rdata = 32'hDEAD_BEEF;
        #1;
        chk("single inst_data_ok", 32'(inst_data_ok), 32'd1);
        chk("single inst_rdata", inst_rdata, 32'hDEAD_BEEF);
        tick();
        rvalid = 0;
        chk("single grant count", dut_grants.size(), 32'd1);

        do_reset();
        inst_req = 1; inst_addr = 32'h100; data_req = 1; data_addr = 32'h200; arready = 1;
        repeat (12) tick();
`ifdef AXI_RD_ARB_RR_EN
        exp_seq = '{1, 0, 1, 0};
`else
        exp_seq = '{1, 1, 0, 0};
`endif
        chk("contention grant count", dut_grants.size(), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < dut_grants.size()) chk($sformatf("contention grant %0d", i), dut_grants[i], exp_seq[i]);

        do_reset();
        wr_pend = 1; wr_pend_addr = 32'h1004; data_req = 1; data_addr = 32'h1006; arready = 1;
        repeat (4) tick();
        chk("raw held", dut_grants.size(), 32'd0);
        wr_pend = 0;
        tick();
        chk("raw released", dut_grants.size(), 32'd1);
        data_req = 0;
        tick();
        wr_pend = 1; data_addr = 32'h1008; data_req = 1;
        tick();
        data_req = 0;
        chk("raw other word", dut_grants.size(), 32'd2);
        tick();

        do_reset();
        inst_req = 1; inst_addr = 32'h300;
        tick();
        inst_req = 0; data_req = 1; data_addr = 32'h304;
        repeat (4) tick();
        chk("backpressure grants", dut_grants.size(), 32'd1);
        arready = 1;
        repeat (2) tick();
        data_req = 0;
        chk("backpressure after", dut_grants.size(), 32'd2);
        tick();

        do_reset();
        arready = 1; data_req = 1; data_addr = 32'h400;
        tick();
        data_req = 0;
        tick();
        arready = 0; data_req = 1; data_addr = 32'h404;
        tick();
        data_req = 0;
        tick();
        arready = 1; rvalid = 1; rid = 1; rdata = 32'h1111_2222;
        tick();
        rid = 0; rdata = 32'h3333_4444;
        tick();
        rvalid = 0;
        dut_grants.delete();
        inst_req = 1; inst_addr = 32'h500; data_req = 1; data_addr = 32'h504;
        repeat (10) tick();
        chk("simul data grants", count_id(1), 32'd1);
        chk("simul inst grants", count_id(0), 32'd2);

        do_reset();
        for (int i = 0; i < 2500; i++) begin
            aresetn = $urandom_range(0, 199) != 0;
            inst_req = $urandom_range(0, 1) == 1;
            inst_addr = $urandom;
            inst_size = 2'($urandom_range(0, 2));
            data_req = $urandom_range(0, 1) == 1;
            data_addr = {26'h0, 6'($urandom)};
            data_size = 2'($urandom_range(0, 2));
            wr_pend = $urandom_range(0, 2) == 0;
            wr_pend_addr = {26'h0, 6'($urandom)};
            arready = $urandom_range(0, 99) < 60;
            rvalid = $urandom_range(0, 1) == 1;
            rid = $urandom_range(0, 9) == 0 ? 4'($urandom) : 4'($urandom_range(0, 1));
            rdata = $urandom;
            tick();
        end
        @(negedge aclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
